// File: rtl/regfile_writeback_queue_if.sv
// Writeback bus between the ALU/load producers, the register file write port and
// the forwarding lookups. The master side drives requests; the slave side is the queue.
interface regfile_writeback_queue_if #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              MemValid, MemReady;
  logic [ADDR_W-1:0] MemReg;
  logic [WIDTH-1:0]  MemData;
  logic              AluValid, AluReady;
  logic [ADDR_W-1:0] AluReg;
  logic [WIDTH-1:0]  AluData;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] LookupReg1, LookupReg2;
  logic              LookupHit1, LookupHit2;
  logic [WIDTH-1:0]  LookupData1, LookupData2;
  logic [CNT_W-1:0]  Count;

  modport master (
    output MemValid, MemReg, MemData, AluValid, AluReg, AluData, LookupReg1, LookupReg2,
    input  MemReady, AluReady, RegWrite, WriteRegister, WriteData,
           LookupHit1, LookupHit2, LookupData1, LookupData2, Count
  );
  modport slave (
    input  MemValid, MemReg, MemData, AluValid, AluReg, AluData, LookupReg1, LookupReg2,
    output MemReady, AluReady, RegWrite, WriteRegister, WriteData,
           LookupHit1, LookupHit2, LookupData1, LookupData2, Count
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue feeding the register file's single write port, with
// youngest-match forwarding for both read ports. Load writebacks are older than ALU.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input logic Clk,
  input logic Reset_n,
  regfile_writeback_queue_if.slave wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] entReg  [DEPTH];
  logic [WIDTH-1:0]  entData [DEPTH];
  logic [PTR_W-1:0]  head, tail, aluSlot, idx;
  logic [CNT_W-1:0]  count, free;
  logic              pop, memStore, aluStore;
  logic              hit1, hit2;
  logic [WIDTH-1:0]  data1, data2;

  // The head pops every cycle it is valid, so its slot is reusable this cycle.
  assign pop      = (count != '0);
  assign free     = CNT_W'(DEPTH) - count + CNT_W'(pop);
  assign wb.MemReady = (free >= CNT_W'(1));
  assign wb.AluReady = (free >= CNT_W'(2)) | ((free >= CNT_W'(1)) & ~wb.MemValid);

  // Writes to r0 are handshaken but dropped.
  assign memStore = wb.MemValid & wb.MemReady & (wb.MemReg != '0);
  assign aluStore = wb.AluValid & wb.AluReady & (wb.AluReg != '0);
  assign aluSlot  = memStore ? tail + PTR_W'(1) : tail;

  assign wb.RegWrite      = pop;
  assign wb.WriteRegister = pop ? entReg[head]  : '0;
  assign wb.WriteData     = pop ? entData[head] : '0;
  assign wb.Count         = count;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PTR_W'(1);
      tail  <= tail + PTR_W'(memStore) + PTR_W'(aluStore);
      count <= count + CNT_W'(memStore) + CNT_W'(aluStore) - CNT_W'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (memStore) begin
      entReg[tail]  <= wb.MemReg;
      entData[tail] <= wb.MemData;
    end
    if (aluStore) begin
      entReg[aluSlot]  <= wb.AluReg;
      entData[aluSlot] <= wb.AluData;
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    data1 = '0;
    data2 = '0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (wb.LookupReg1 != '0 && entReg[idx] == wb.LookupReg1) begin
          hit1  = 1'b1;
          data1 = entData[idx];
        end
        if (wb.LookupReg2 != '0 && entReg[idx] == wb.LookupReg2) begin
          hit2  = 1'b1;
          data2 = entData[idx];
        end
      end
    end
  end

  assign wb.LookupHit1  = hit1;
  assign wb.LookupHit2  = hit2;
  assign wb.LookupData1 = data1;
  assign wb.LookupData2 = data2;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench: stimulus pushes expected register writes to a scoreboard that a
// negedge monitor drains against the write port; state checks are hand-computed.
module tb_regfile_writeback_queue;
  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  regfile_writeback_queue_if #(.DEPTH(4), .WIDTH(32), .ADDR_W(5)) bus ();
  regfile_writeback_queue #(.DEPTH(4), .WIDTH(32), .ADDR_W(5)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .wb(bus.slave)
  );

  typedef struct { logic [4:0] r; logic [31:0] d; } wr_t;
  wr_t sb[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.MemValid = 1'b0;
    bus.AluValid = 1'b0;
  endtask

  task automatic mem(input logic [4:0] r, input logic [31:0] d);
    bus.MemValid = 1'b1; bus.MemReg = r; bus.MemData = d;
  endtask

  task automatic alu(input logic [4:0] r, input logic [31:0] d);
    bus.AluValid = 1'b1; bus.AluReg = r; bus.AluData = d;
  endtask

  // Scoreboard monitor: every committed write must match the oldest expected one.
  initial begin
    wr_t e;
    forever begin
      @(negedge Clk);
      if (Reset_n && bus.RegWrite) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL wr_unexpected: got r%0d=%0h want none", bus.WriteRegister, bus.WriteData);
        end else begin
          e = sb.pop_front();
          if (bus.WriteRegister !== e.r || bus.WriteData !== e.d) begin
            bad++;
            $display("FAIL wr_data: got r%0d=%0h want r%0d=%0h",
                     bus.WriteRegister, bus.WriteData, e.r, e.d);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  int expCount [6] = '{0, 2, 3, 4, 4, 4};
  int expAluRdy[6] = '{1, 1, 1, 0, 0, 1};

  initial begin
    int n;
    logic [4:0] aReg;
    Reset_n = 1'b1;
    idle();
    bus.MemReg = '0; bus.MemData = '0; bus.AluReg = '0; bus.AluData = '0;
    bus.LookupReg1 = '0; bus.LookupReg2 = '0;
    #1 Reset_n = 1'b0;

    // Reset with a request pending
    mem(5'd7, 32'h77);
    bus.LookupReg1 = 5'd7;
    repeat (2) @(posedge Clk);
    #3;
    check("rst_RegWrite", bus.RegWrite, 0);
    check("rst_Count", bus.Count, 0);
    check("rst_WrReg", bus.WriteRegister, 0);
    check("rst_WrData", bus.WriteData, 0);
    check("rst_Hit1", bus.LookupHit1, 0);
    idle();
    cyc(); Reset_n = 1'b1; #2;
    check("rel_MemReady", bus.MemReady, 1);
    check("rel_AluReady", bus.AluReady, 1);

    // Single ALU write
    cyc(); alu(5'd5, 32'hDEADBEEF); bus.LookupReg1 = 5'd5; push(5'd5, 32'hDEADBEEF); #2;
    check("one_AluReady", bus.AluReady, 1);
    check("one_noFwdIncoming", bus.LookupHit1, 0);
    cyc(); idle(); #2;
    check("one_RegWrite", bus.RegWrite, 1);
    check("one_WrReg", bus.WriteRegister, 5);
    check("one_Count", bus.Count, 1);
    check("one_Hit1", bus.LookupHit1, 1);
    check("one_Data1", bus.LookupData1, 32'hDEADBEEF);
    cyc(); #2;
    check("one_CountAfter", bus.Count, 0);
    check("one_HitAfter", bus.LookupHit1, 0);
    check("one_RegWriteAfter", bus.RegWrite, 0);

    // Same-cycle collision on r3: load first, ALU value is youngest
    cyc(); mem(5'd3, 32'h11); alu(5'd3, 32'h22); bus.LookupReg2 = 5'd3;
    push(5'd3, 32'h11); push(5'd3, 32'h22); #2;
    check("col_AluReady", bus.AluReady, 1);
    check("col_noFwdIncoming", bus.LookupHit2, 0);
    cyc(); idle(); #2;
    check("col_Count2", bus.Count, 2);
    check("col_WrData0", bus.WriteData, 32'h11);
    check("col_Hit2", bus.LookupHit2, 1);
    check("col_Data2young", bus.LookupData2, 32'h22);
    cyc(); #2;
    check("col_Count1", bus.Count, 1);
    check("col_WrData1", bus.WriteData, 32'h22);
    check("col_Data2last", bus.LookupData2, 32'h22);
    cyc(); #2;
    check("col_Count0", bus.Count, 0);
    check("col_Hit2gone", bus.LookupHit2, 0);

    // Back-pressure: both producers every cycle, ALU holds when refused
    aReg = 5'd16;
    bus.LookupReg1 = 5'd11;
    bus.LookupReg2 = 5'd9;
    for (int k = 0; k < 6; k++) begin
      cyc();
      idle();
      if (k < 5) mem(5'(8 + k), 32'h100 + 32'(8 + k));
      alu(aReg, 32'h200 + 32'(aReg));
      #2;
      check($sformatf("bp_Count%0d", k), bus.Count, expCount[k]);
      check($sformatf("bp_AluReady%0d", k), bus.AluReady, expAluRdy[k]);
      check($sformatf("bp_MemReady%0d", k), bus.MemReady, 1);
      if (k < 5) push(5'(8 + k), 32'h100 + 32'(8 + k));
      if (expAluRdy[k] != 0) begin
        push(aReg, 32'h200 + 32'(aReg));
        aReg = aReg + 5'd1;
      end
    end
    // Queue now r10,r18,r11,r12: r9 already committed, r11 pending
    check("bp_Hit1", bus.LookupHit1, 1);
    check("bp_Data1", bus.LookupData1, 32'h10B);
    check("bp_Hit2retired", bus.LookupHit2, 0);
    cyc(); idle(); #2;
    check("bp_CountFull", bus.Count, 4);
    n = 0;
    while (bus.Count != 0 && n < 20) begin cyc(); #2; n++; end
    check("bp_drained", bus.Count, 0);
    check("bp_sbEmpty", sb.size(), 0);

    // Register 0 is consumed but never stored
    cyc(); alu(5'd0, 32'hFFFFFFFF); bus.LookupReg1 = 5'd0; #2;
    check("r0_AluReady", bus.AluReady, 1);
    cyc(); idle(); mem(5'd0, 32'h5); alu(5'd4, 32'h44); push(5'd4, 32'h44); #2;
    check("r0_Count", bus.Count, 0);
    check("r0_RegWrite", bus.RegWrite, 0);
    check("r0_Hit1", bus.LookupHit1, 0);
    cyc(); idle(); #2;
    check("r0_CountAlu", bus.Count, 1);
    check("r0_WrReg", bus.WriteRegister, 4);
    check("r0_Hit1stillMiss", bus.LookupHit1, 0);
    cyc(); #2;
    check("r0_CountEnd", bus.Count, 0);

    // Reset while three writes are queued
    cyc(); mem(5'd1, 32'hA1); alu(5'd2, 32'hA2); push(5'd1, 32'hA1); push(5'd2, 32'hA2);
    cyc(); mem(5'd6, 32'hA6); alu(5'd7, 32'hA7); push(5'd6, 32'hA6); push(5'd7, 32'hA7); #2;
    check("mr_Count2", bus.Count, 2);
    cyc(); idle(); #1;
    check("mr_Count3", bus.Count, 3);
    Reset_n = 1'b0;
    #1;
    check("mr_RegWrite", bus.RegWrite, 0);
    check("mr_Count", bus.Count, 0);
    check("mr_WrData", bus.WriteData, 0);
    sb.delete();
    repeat (2) cyc();
    Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); #2;
      check($sformatf("mr_noWrite%0d", k), bus.RegWrite, 0);
    end
    check("mr_CountPost", bus.Count, 0);
    check("end_sbEmpty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
